// File: rtl/alu_program_sequencer.sv
// Program sequencer for the 4-bit accumulator ALU: fetches instructions from a
// switch-loaded 16x8 memory and drives OPR/OPA with a two-phase EXEC strobe.
module alu_program_sequencer #(
  parameter int HI_CYC = 4,
  parameter int LO_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LOAD_WE,
  input  logic [3:0] LOAD_ADDR,
  input  logic [7:0] LOAD_DATA,
  input  logic       RUN,
  input  logic       STEP,
  input  logic       PC_CLR,
  output logic [3:0] OPR_OUT,
  output logic [3:0] OPA_OUT,
  output logic       EXEC,
  output logic [3:0] PC,
  output logic       BUSY,
  output logic       HALTED
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_ISSUE_HI = 3'd2;
  localparam logic [2:0] S_ISSUE_LO = 3'd3;
  localparam logic [2:0] S_HALTED   = 3'd4;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_JUMP = 4'hF;

  localparam int MAX_CYC = (HI_CYC > LO_CYC) ? HI_CYC : LO_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HI_CYC - 1);
  localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [7:0]       mem [16];
  logic [7:0]       instr;
  logic             mem_we;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       pc_nxt;
  logic [3:0]       opr_nxt;
  logic [3:0]       opa_nxt;
  logic             step_mode;
  logic             step_mode_nxt;
  logic             continuing;

  // Memory is only writable while the sequencer is parked, never while issuing.
  assign mem_we = LOAD_WE && ((state == S_IDLE) || (state == S_HALTED));

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[LOAD_ADDR] <= LOAD_DATA;
    end
  end

  assign instr      = mem[PC];
  assign continuing = RUN && !step_mode;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pc_nxt        = PC;
    opr_nxt       = OPR_OUT;
    opa_nxt       = OPA_OUT;
    step_mode_nxt = step_mode;
    case (state)
      S_IDLE: begin
        if (PC_CLR) begin
          pc_nxt = 4'd0;
        end else if (RUN || STEP) begin
          state_nxt     = S_FETCH;
          step_mode_nxt = !RUN;
        end
      end
      S_FETCH: begin
        if (instr[7:4] == OP_HALT) begin
          state_nxt = S_HALTED;
        end else if (instr[7:4] == OP_JUMP) begin
          pc_nxt    = instr[3:0];
          state_nxt = continuing ? S_FETCH : S_IDLE;
        end else begin
          opr_nxt   = instr[7:4];
          opa_nxt   = instr[3:0];
          cnt_nxt   = '0;
          state_nxt = S_ISSUE_HI;
        end
      end
      S_ISSUE_HI: begin
        if (cnt == HI_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_ISSUE_LO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_ISSUE_LO: begin
        // RUN is only consulted here, so a dropped RUN never shortens a strobe.
        if (cnt == LO_LAST) begin
          cnt_nxt   = '0;
          pc_nxt    = PC + 4'd1;
          state_nxt = continuing ? S_FETCH : S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_HALTED: begin
        if (PC_CLR) begin
          pc_nxt    = 4'd0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so EXEC is glitch-free.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      PC        <= 4'd0;
      OPR_OUT   <= 4'd0;
      OPA_OUT   <= 4'd0;
      step_mode <= 1'b0;
      EXEC      <= 1'b0;
      BUSY      <= 1'b0;
      HALTED    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      PC        <= pc_nxt;
      OPR_OUT   <= opr_nxt;
      OPA_OUT   <= opa_nxt;
      step_mode <= step_mode_nxt;
      EXEC      <= (state_nxt == S_ISSUE_HI);
      BUSY      <= (state_nxt == S_FETCH) || (state_nxt == S_ISSUE_HI) ||
                   (state_nxt == S_ISSUE_LO);
      HALTED    <= (state_nxt == S_HALTED);
    end
  end

endmodule
